// File: rtl/cpu_test_seq_if.sv
// Request/acknowledge memory bus between the test sequencer (master) and the
// device or memory under bring-up (slave).
interface cpu_test_seq_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32
);
  logic              memrq;
  logic              memwr;
  logic              memack;
  logic              memdone;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] busin;
  logic [DATA_W-1:0] busout;

  modport master (
    output memrq, memwr, addr, busout,
    input  memack, memdone, busin
  );

  modport slave (
    input  memrq, memwr, addr, busout,
    output memack, memdone, busin
  );
endinterface

// File: rtl/cpu_test_seq.sv
// Microcoded test sequencer: runs a program from a 1-cycle synchronous ROM,
// issues req/ack bus cycles and halts on DONE or on a sticky fault.
module cpu_test_seq #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 22,
  parameter  int PC_W   = 8,
  parameter  int TMO_W  = 10,
  localparam int IW     = 10 + PC_W + DATA_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [PC_W-1:0] prog_addr,
  input  logic [IW-1:0]   prog_data,
  cpu_test_seq_if.master  busint,
  output logic            done,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic [PC_W-1:0] pc_out
);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_WRITE = 4'd1,
    OP_READ  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_TST   = 4'd5,
    OP_CMP   = 4'd6,
    OP_JMP   = 4'd7,
    OP_DONE  = 4'd8,
    OP_WAIT  = 4'd9,
    OP_FAULT = 4'd15
  } op_e;

  typedef enum logic [1:0] {M_IDLE, M_REQ, M_WAIT, M_DONE} mem_state_e;

  // Architectural state
  logic [PC_W-1:0]   pc;
  logic              bubble;
  logic [DATA_W-1:0] regs [8];
  logic              done_q;
  logic              fault_q;
  logic [1:0]        fault_code_q;
  logic              wait_run;
  logic [TMO_W-1:0]  wait_left;

  // Bus engine state
  mem_state_e        state, state_d;
  logic              wr_q, wr_d;
  logic              memrq_q, memwr_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              xfer_ok;

  // Decode
  logic [3:0]        op;
  logic [2:0]        dreg, sreg;
  logic [PC_W-1:0]   nxt, npc;
  logic [DATA_W-1:0] imm, src, dst, alu;
  logic [TMO_W-1:0]  wait_n;
  logic              halted, is_bus, is_illegal, is_halt_op, wait_exp;
  logic              stall, advance, branch, bus_go, tmo_hit, op_fault, rd_load;

  // The instruction slot is a bubble right after reset or a restart, until the
  // first fetch from address 0 has actually been issued.
  assign op     = bubble ? 4'(OP_NOP) : prog_data[IW-1 -: 4];
  assign dreg   = prog_data[IW-5 -: 3];
  assign sreg   = prog_data[IW-8 -: 3];
  assign nxt    = prog_data[DATA_W +: PC_W];
  assign imm    = prog_data[DATA_W-1:0];
  assign wait_n = imm[TMO_W-1:0];

  assign halted     = done_q | fault_q;
  assign is_bus     = (op == OP_WRITE) || (op == OP_READ);
  assign is_illegal = (op >= 4'd10) && (op <= 4'd14);
  assign is_halt_op = (op == OP_DONE) || (op == OP_FAULT) || is_illegal;
  assign tmo_hit    = ((state == M_REQ) || (state == M_WAIT)) && (&tmo_cnt);
  assign op_fault   = start && !halted && ((op == OP_FAULT) || is_illegal);
  assign bus_go     = (state == M_IDLE) && is_bus && !xfer_ok && start && !halted;
  assign rd_load    = busint.memdone && !wr_q && ((state == M_REQ) || (state == M_WAIT));

  // WAIT occupies the instruction slot for max(imm,1) cycles in total.
  assign wait_exp = wait_run ? (wait_left <= TMO_W'(1)) : (wait_n <= TMO_W'(1));

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    src = regs[sreg];
    dst = regs[dreg];
    if (sreg == 3'd0) src = imm;
    if (dreg == 3'd0) dst = '0;
    alu = src - imm;
    if (op == OP_ADD) alu = (sreg == 3'd0) ? imm : src + imm;
  end

  assign stall = !start || halted || is_halt_op ||
                 ((op == OP_WAIT) && !wait_exp) ||
                 (is_bus && (state != M_DONE) && !xfer_ok);
  assign advance = !stall;
  assign branch  = advance && ((op == OP_JMP) ||
                               ((op == OP_TST) && ((dst & src) == '0)) ||
                               ((op == OP_CMP) && (dst == src)));
  assign npc       = branch ? nxt : pc + 1'b1;
  assign prog_addr = stall ? pc : npc;

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register file is reset like ordinary flops because r1/r2 are
      // directly visible on the bus outputs straight out of reset.
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      pc           <= '1;
      bubble       <= 1'b1;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'd0;
      wait_run     <= 1'b0;
      wait_left    <= '0;
    end else begin
      if (done_q && !start) begin
        done_q <= 1'b0;
        pc     <= '1;
        bubble <= 1'b1;
      end else begin
        if (advance) begin
          pc     <= npc;
          bubble <= 1'b0;
        end
        if ((op == OP_DONE) && start && !halted) done_q <= 1'b1;
      end

      if (!fault_q && (tmo_hit || op_fault)) begin
        fault_q      <= 1'b1;
        fault_code_q <= tmo_hit ? 2'd2 : ((op == OP_FAULT) ? 2'd1 : 2'd3);
      end

      if (advance || halted) begin
        wait_run <= 1'b0;
      end else if ((op == OP_WAIT) && start) begin
        if (!wait_run) begin
          wait_run  <= 1'b1;
          wait_left <= wait_n - 1'b1;
        end else if (wait_left > TMO_W'(1)) begin
          wait_left <= wait_left - 1'b1;
        end
      end

      // A bus read result lands in r2 even while the pc is stalled, and beats
      // an ADD/SUB to r2 in the same cycle.
      if (rd_load) regs[2] <= busint.busin;
      if (advance && ((op == OP_ADD) || (op == OP_SUB)) && (dreg != 3'd0) &&
          !(rd_load && (dreg == 3'd2)))
        regs[dreg] <= alu;
    end
  end

  always_comb begin
    state_d = state;
    wr_d    = bus_go ? (op == OP_WRITE) : wr_q;
    case (state)
      M_IDLE: if (bus_go) state_d = M_REQ;
      M_REQ:  if (tmo_hit) state_d = M_IDLE;
              else if (busint.memack) state_d = M_WAIT;
      M_WAIT: if (tmo_hit) state_d = M_IDLE;
              else if (!busint.memack) state_d = M_DONE;
      M_DONE: state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  // memrq/memwr come straight from flops so the bus sees glitch-free strobes
  // aligned with the REQ state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= M_IDLE;
      wr_q    <= 1'b0;
      memrq_q <= 1'b0;
      memwr_q <= 1'b0;
      tmo_cnt <= '0;
      xfer_ok <= 1'b0;
    end else begin
      state   <= state_d;
      wr_q    <= wr_d;
      memrq_q <= (state_d == M_REQ);
      memwr_q <= (state_d == M_REQ) && wr_d;
      if (bus_go)
        tmo_cnt <= TMO_W'(1);
      else if ((state == M_REQ) || (state == M_WAIT))
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;
      // Remember a finished transfer while start is low so it is not reissued.
      if (advance)
        xfer_ok <= 1'b0;
      else if (state == M_DONE)
        xfer_ok <= 1'b1;
    end
  end

  assign busint.memrq  = memrq_q;
  assign busint.memwr  = memwr_q;
  assign busint.addr   = regs[1][ADDR_W-1:0];
  assign busint.busout = regs[2];
  assign done          = done_q;
  assign fault         = fault_q;
  assign fault_code    = fault_code_q;
  assign pc_out        = pc;

endmodule
